// File: rtl/axi_cdc_txn_gate.sv
// axi_cdc_txn_gate: source-side AXI handshake gate that caps outstanding txns and sequences isolate/drain
//   clk_i, rst_i          clock, async active-high reset
//   isolate_i/isolated_o  isolation request level / registered ISOLATED indication
//   slv_*/mst_*           AW/W/B/AR/R valid-ready pairs, upstream master side / CDC side
//   wr_cnt_o, rd_cnt_o    outstanding write/read counts; cnt_err_o sticky underflow flag
module axi_cdc_txn_gate #(
   parameter int MaxWrTxns = 12,
   parameter int MaxRdTxns = 10,
   parameter int CntWidth  = $clog2(((MaxWrTxns > MaxRdTxns) ? MaxWrTxns : MaxRdTxns) + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                isolate_i,
   output logic                isolated_o,
   input  logic                slv_aw_valid_i,
   output logic                slv_aw_ready_o,
   output logic                mst_aw_valid_o,
   input  logic                mst_aw_ready_i,
   input  logic                slv_w_valid_i,
   output logic                slv_w_ready_o,
   output logic                mst_w_valid_o,
   input  logic                mst_w_ready_i,
   input  logic                mst_b_valid_i,
   output logic                mst_b_ready_o,
   output logic                slv_b_valid_o,
   input  logic                slv_b_ready_i,
   input  logic                slv_ar_valid_i,
   output logic                slv_ar_ready_o,
   output logic                mst_ar_valid_o,
   input  logic                mst_ar_ready_i,
   input  logic                mst_r_valid_i,
   output logic                mst_r_ready_o,
   output logic                slv_r_valid_o,
   input  logic                slv_r_ready_i,
   input  logic                mst_r_last_i,
   output logic [CntWidth-1:0] wr_cnt_o,
   output logic [CntWidth-1:0] rd_cnt_o,
   output logic                cnt_err_o
);
   typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_e;
   localparam logic [CntWidth-1:0] WrMax = CntWidth'(MaxWrTxns);
   localparam logic [CntWidth-1:0] RdMax = CntWidth'(MaxRdTxns);
   state_e state_q, state_d;
   logic [CntWidth-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic aw_hold_q, aw_hold_d, ar_hold_q, ar_hold_d;
   logic cnt_err_q, cnt_err_d, isolated_q, isolated_d;
   logic allow_aw, allow_ar, w_en;
   logic aw_hs, b_hs, ar_hs, rl_hs, idle_d;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         aw_hold_q  <= 1'b0;
         ar_hold_q  <= 1'b0;
         cnt_err_q  <= 1'b0;
         isolated_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_cnt_q   <= rd_cnt_d;
         aw_hold_q  <= aw_hold_d;
         ar_hold_q  <= ar_hold_d;
         cnt_err_q  <= cnt_err_d;
         isolated_q <= isolated_d;
      end
   end
   // Counters and holds; simultaneous inc+dec nets to no change and is never an underflow.
   always_comb begin
      aw_hs     = mst_aw_valid_o & mst_aw_ready_i;
      b_hs      = mst_b_valid_i & slv_b_ready_i;
      ar_hs     = mst_ar_valid_o & mst_ar_ready_i;
      rl_hs     = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;
      wr_cnt_d  = (aw_hs && !b_hs) ? ((wr_cnt_q == WrMax) ? wr_cnt_q : wr_cnt_q + 1'b1) :
                  (b_hs && !aw_hs) ? ((wr_cnt_q == '0) ? '0 : wr_cnt_q - 1'b1) : wr_cnt_q;
      rd_cnt_d  = (ar_hs && !rl_hs) ? ((rd_cnt_q == RdMax) ? rd_cnt_q : rd_cnt_q + 1'b1) :
                  (rl_hs && !ar_hs) ? ((rd_cnt_q == '0) ? '0 : rd_cnt_q - 1'b1) : rd_cnt_q;
      cnt_err_d = cnt_err_q | (b_hs & ~aw_hs & (wr_cnt_q == '0)) | (rl_hs & ~ar_hs & (rd_cnt_q == '0));
      aw_hold_d = mst_aw_valid_o & ~mst_aw_ready_i;
      ar_hold_d = mst_ar_valid_o & ~mst_ar_ready_i;
   end
   // Drain completes on next-state values so isolation lands on the edge that retires the last txn.
   always_comb begin
      idle_d     = (wr_cnt_d == '0) && (rd_cnt_d == '0) && !aw_hold_d && !ar_hold_d;
      state_d    = (state_q == RUN) ? (isolate_i ? DRAIN : RUN) :
                   !isolate_i ? RUN :
                   (state_q == ISOLATED || idle_d) ? ISOLATED : DRAIN;
      isolated_d = state_d == ISOLATED;
   end
   // A presented AW/AR stays open until accepted, regardless of limit or isolation.
   always_comb begin
      allow_aw = aw_hold_q | (state_q == RUN && wr_cnt_q < WrMax);
      allow_ar = ar_hold_q | (state_q == RUN && rd_cnt_q < RdMax);
      w_en     = state_q != ISOLATED;
   end
   assign mst_aw_valid_o = slv_aw_valid_i & allow_aw;
   assign slv_aw_ready_o = mst_aw_ready_i & allow_aw;
   assign mst_ar_valid_o = slv_ar_valid_i & allow_ar;
   assign slv_ar_ready_o = mst_ar_ready_i & allow_ar;
   assign mst_w_valid_o  = slv_w_valid_i & w_en;
   assign slv_w_ready_o  = mst_w_ready_i & w_en;
   assign slv_b_valid_o  = mst_b_valid_i;
   assign mst_b_ready_o  = slv_b_ready_i;
   assign slv_r_valid_o  = mst_r_valid_i;
   assign mst_r_ready_o  = slv_r_ready_i;
   assign wr_cnt_o       = wr_cnt_q;
   assign rd_cnt_o       = rd_cnt_q;
   assign cnt_err_o      = cnt_err_q;
   assign isolated_o     = isolated_q;
endmodule

// File: tb/tb_axi_cdc_txn_gate.sv
// tb_axi_cdc_txn_gate: directed self-checking bench for axi_cdc_txn_gate
module tb_axi_cdc_txn_gate;
   logic clk_i = 1'b0, rst_i = 1'b1, isolate_i = 1'b0, isolated_o;
   logic slv_aw_valid_i = 1'b0, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i = 1'b0;
   logic slv_w_valid_i = 1'b0, slv_w_ready_o, mst_w_valid_o, mst_w_ready_i = 1'b0;
   logic mst_b_valid_i = 1'b0, mst_b_ready_o, slv_b_valid_o, slv_b_ready_i = 1'b0;
   logic slv_ar_valid_i = 1'b0, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i = 1'b0;
   logic mst_r_valid_i = 1'b0, mst_r_ready_o, slv_r_valid_o, slv_r_ready_i = 1'b0, mst_r_last_i = 1'b0;
   logic [3:0] wr_cnt_o, rd_cnt_o;
   logic cnt_err_o;
   int n_checks = 0, n_err = 0;
   axi_cdc_txn_gate dut (
      .clk_i(clk_i), .rst_i(rst_i), .isolate_i(isolate_i), .isolated_o(isolated_o),
      .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o),
      .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i),
      .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o),
      .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
      .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
      .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i),
      .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
      .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i),
      .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o),
      .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i), .mst_r_last_i(mst_r_last_i),
      .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o), .cnt_err_o(cnt_err_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask
   always @(negedge clk_i) begin
      if (wr_cnt_o > 4'd12) check("wr_ovf", wr_cnt_o, 12);
      if (rd_cnt_o > 4'd10) check("rd_ovf", rd_cnt_o, 10);
   end
   initial begin
      repeat (2) tick;
      check("rst_wr", wr_cnt_o, 0);
      check("rst_rd", rd_cnt_o, 0);
      check("rst_iso", isolated_o, 0);
      check("rst_err", cnt_err_o, 0);
      check("rst_awr", slv_aw_ready_o, 0);
      rst_i = 1'b0;
      mst_aw_ready_i = 1'b1;
      mst_ar_ready_i = 1'b1;
      slv_aw_valid_i = 1'b1;
      #1;
      check("lim_open", slv_aw_ready_o, 1);
      repeat (12) tick;
      check("lim_wr12", wr_cnt_o, 12);
      check("lim_rdy0", slv_aw_ready_o, 0);
      check("lim_val0", mst_aw_valid_o, 0);
      tick;
      check("lim_stay", wr_cnt_o, 12);
      mst_b_valid_i = 1'b1;
      slv_b_ready_i = 1'b1;
      #1;
      check("b_pass_v", slv_b_valid_o, 1);
      check("b_pass_r", mst_b_ready_o, 1);
      check("lim_rdy_b", slv_aw_ready_o, 0);
      tick;
      mst_b_valid_i = 1'b0;
      #1;
      check("lim_wr11", wr_cnt_o, 11);
      check("lim_reopen", slv_aw_ready_o, 1);
      tick;
      slv_aw_valid_i = 1'b0;
      check("lim_13th", wr_cnt_o, 12);
      mst_b_valid_i = 1'b1;
      repeat (7) tick;
      check("sim_wr5", wr_cnt_o, 5);
      slv_aw_valid_i = 1'b1;
      tick;
      slv_aw_valid_i = 1'b0;
      check("sim_same", wr_cnt_o, 5);
      repeat (5) tick;
      mst_b_valid_i = 1'b0;
      check("sim_wr0", wr_cnt_o, 0);
      slv_ar_valid_i = 1'b1;
      tick;
      slv_ar_valid_i = 1'b0;
      check("rd_inc", rd_cnt_o, 1);
      mst_r_valid_i = 1'b1;
      slv_r_ready_i = 1'b1;
      #1;
      check("r_pass_v", slv_r_valid_o, 1);
      check("r_pass_r", mst_r_ready_o, 1);
      tick;
      check("r_nolast", rd_cnt_o, 1);
      mst_r_last_i = 1'b1;
      tick;
      mst_r_valid_i = 1'b0;
      check("r_last", rd_cnt_o, 0);
      check("no_err", cnt_err_o, 0);
      slv_aw_valid_i = 1'b1;
      slv_ar_valid_i = 1'b1;
      repeat (2) tick;
      slv_ar_valid_i = 1'b0;
      tick;
      slv_aw_valid_i = 1'b0;
      check("dr_wr3", wr_cnt_o, 3);
      check("dr_rd2", rd_cnt_o, 2);
      isolate_i = 1'b1;
      tick;
      slv_aw_valid_i = 1'b1;
      slv_ar_valid_i = 1'b1;
      slv_w_valid_i = 1'b1;
      mst_w_ready_i = 1'b1;
      #1;
      check("dr_aw_blk", mst_aw_valid_o, 0);
      check("dr_ar_blk", slv_ar_ready_o, 0);
      check("dr_w_v", mst_w_valid_o, 1);
      check("dr_w_r", slv_w_ready_o, 1);
      check("dr_iso0", isolated_o, 0);
      slv_aw_valid_i = 1'b0;
      slv_ar_valid_i = 1'b0;
      mst_b_valid_i = 1'b1;
      mst_r_valid_i = 1'b1;
      repeat (2) tick;
      mst_r_valid_i = 1'b0;
      check("dr_wait", isolated_o, 0);
      check("dr_wr1", wr_cnt_o, 1);
      tick;
      mst_b_valid_i = 1'b0;
      #1;
      check("dr_iso1", isolated_o, 1);
      check("dr_cnt0", {wr_cnt_o, rd_cnt_o}, 0);
      check("iso_w_v", mst_w_valid_o, 0);
      check("iso_w_r", slv_w_ready_o, 0);
      isolate_i = 1'b0;
      tick;
      check("rel_iso0", isolated_o, 0);
      check("rel_w", mst_w_valid_o, 1);
      slv_w_valid_i = 1'b0;
      mst_aw_ready_i = 1'b0;
      slv_aw_valid_i = 1'b1;
      #1;
      check("hold_v", mst_aw_valid_o, 1);
      check("hold_r", slv_aw_ready_o, 0);
      tick;
      isolate_i = 1'b1;
      tick;
      check("hold_keep", mst_aw_valid_o, 1);
      check("hold_iso0", isolated_o, 0);
      mst_aw_ready_i = 1'b1;
      #1;
      check("hold_acc", slv_aw_ready_o, 1);
      tick;
      check("hold_wr1", wr_cnt_o, 1);
      check("hold_shut", mst_aw_valid_o, 0);
      slv_aw_valid_i = 1'b0;
      tick;
      check("hold_wait", isolated_o, 0);
      mst_b_valid_i = 1'b1;
      tick;
      mst_b_valid_i = 1'b0;
      check("hold_iso1", isolated_o, 1);
      check("hold_wr0", wr_cnt_o, 0);
      isolate_i = 1'b0;
      tick;
      check("iso_rel", isolated_o, 0);
      slv_aw_valid_i = 1'b1;
      tick;
      slv_aw_valid_i = 1'b0;
      isolate_i = 1'b1;
      tick;
      slv_aw_valid_i = 1'b1;
      #1;
      check("ab_blk", slv_aw_ready_o, 0);
      isolate_i = 1'b0;
      tick;
      check("ab_open", slv_aw_ready_o, 1);
      check("ab_iso0", isolated_o, 0);
      tick;
      slv_aw_valid_i = 1'b0;
      check("ab_wr2", wr_cnt_o, 2);
      mst_b_valid_i = 1'b1;
      repeat (2) tick;
      check("ab_wr0", wr_cnt_o, 0);
      tick;
      mst_b_valid_i = 1'b0;
      check("err_set", cnt_err_o, 1);
      check("err_wr0", wr_cnt_o, 0);
      tick;
      check("err_sticky", cnt_err_o, 1);
      isolate_i = 1'b1;
      tick;
      check("lat_1", isolated_o, 0);
      tick;
      check("lat_2", isolated_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_iso", isolated_o, 0);
      check("arst_err", cnt_err_o, 0);
      tick;
      isolate_i = 1'b0;
      rst_i = 1'b0;
      slv_aw_valid_i = 1'b1;
      slv_ar_valid_i = 1'b1;
      repeat (2) tick;
      check("burst_cnt", {wr_cnt_o, rd_cnt_o}, 8'h22);
      #2;
      rst_i = 1'b1;
      #1;
      check("arst_wr", wr_cnt_o, 0);
      check("arst_rd", rd_cnt_o, 0);
      slv_aw_valid_i = 1'b0;
      slv_ar_valid_i = 1'b0;
      tick;
      rst_i = 1'b0;
      tick;
      check("post_rst", wr_cnt_o, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
